// File: rtl/vpo_line_unpack.sv
// vpo_line_unpack: reads one line of 128-bit words from the line RAM and streams them out as pixels, and issues DDR prefetch pulses.
// Macro VPO_PIX_MSB_FIRST_EN: when defined, pixel 0 of each word is taken from the top bits.
module vpo_line_unpack #(
  parameter int PIX_W = 16
) (
  input  logic             i_sclk,
  input  logic             i_rst,
  input  logic             i_soft_rst,
  input  logic             i_syn_v,
  input  logic             i_line_start,
  input  logic [11:0]      i_pix_num,
  output logic [7:0]       o_ram_rd_addr,
  output logic             o_ram_rd_en,
  input  logic [127:0]     i_ram_rd_data,
  output logic             o_pix_vld,
  input  logic             i_pix_rdy,
  output logic [PIX_W-1:0] o_pix_data,
  output logic             o_pix_last,
  output logic             o_ddr_req,
  output logic             o_line_err
);
  localparam int NP = 128 / PIX_W;
  localparam int IW = $clog2(NP);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic clr, start, abort, syn_rise, hs, last, cur_done, cur_free, rd_en;
  logic inflight, cur_vld, nxt_vld, line_err;
  logic [2:0] syn_s;
  logic [1:0] ddr_cnt;
  logic [11:0] npix, npix_in, pcnt;
  logic [8:0] nword, nword_in, rcnt;
  logic [IW-1:0] pidx, sel;
  logic [127:0] cur, nxt;
  always_comb begin
    clr = i_rst | i_soft_rst;
    npix_in = (i_pix_num > 12'd2048) ? 12'd2048 : i_pix_num;
    nword_in = 9'((npix_in + 12'd7) >> 3);
    syn_rise = syn_s[1] & ~syn_s[2];
    start = (state == IDLE) & i_line_start & (i_pix_num != 12'd0);
    abort = (state == RUN) & syn_rise;
    hs = cur_vld & i_pix_rdy;
    last = pcnt == npix - 12'd1;
    cur_done = hs & ((pidx == IW'(NP - 1)) | last);
    // returned data may go straight to CUR when CUR drains this cycle with NXT empty
    cur_free = ~cur_vld | (cur_done & ~nxt_vld);
    rd_en = (state == RUN) & ~syn_rise & ~inflight & ~nxt_vld & (rcnt < nword);
    state_nx = (state == IDLE) ? (start ? RUN : IDLE) :
               (state == RUN) ? (abort ? IDLE : (hs & last) ? DONE : RUN) : IDLE;
`ifdef VPO_PIX_MSB_FIRST_EN
    sel = IW'(NP - 1) - pidx;
`else
    sel = pidx;
`endif
  end
  always_ff @(posedge i_sclk) begin
    if (clr) begin
      state <= IDLE;
      syn_s <= '0;
      ddr_cnt <= '0;
      line_err <= 1'b0;
      npix <= '0;
      nword <= '0;
      pcnt <= '0;
      rcnt <= '0;
      pidx <= '0;
      cur <= '0;
      nxt <= '0;
      cur_vld <= 1'b0;
      nxt_vld <= 1'b0;
      inflight <= 1'b0;
    end else begin
      state <= state_nx;
      syn_s <= {syn_s[1:0], i_syn_v};
      line_err <= i_line_start & (state != IDLE);
      ddr_cnt <= ((state == DONE) | syn_rise) ? 2'd3 : ddr_cnt - 2'(ddr_cnt != 2'd0);
      if (start) begin
        npix <= npix_in;
        nword <= nword_in;
        pcnt <= '0;
        rcnt <= '0;
        pidx <= '0;
        cur_vld <= 1'b0;
        nxt_vld <= 1'b0;
        inflight <= 1'b0;
      end else if ((state != RUN) | abort) begin
        cur_vld <= 1'b0;
        nxt_vld <= 1'b0;
        inflight <= 1'b0;
      end else begin
        inflight <= rd_en;
        rcnt <= rcnt + 9'(rd_en);
        if (hs) begin
          pcnt <= pcnt + 12'd1;
          pidx <= cur_done ? '0 : pidx + IW'(1);
        end
        if (inflight & cur_free) begin
          cur <= i_ram_rd_data;
          cur_vld <= 1'b1;
        end else if (cur_done) begin
          cur <= nxt;
          cur_vld <= nxt_vld;
          nxt_vld <= 1'b0;
        end
        if (inflight & ~cur_free) begin
          nxt <= i_ram_rd_data;
          nxt_vld <= 1'b1;
        end
      end
    end
  end
  assign o_pix_vld = cur_vld;
  assign o_pix_data = cur_vld ? cur[sel*PIX_W +: PIX_W] : '0;
  assign o_pix_last = cur_vld & last;
  assign o_ram_rd_en = rd_en;
  assign o_ram_rd_addr = rd_en ? rcnt[7:0] : '0;
  assign o_ddr_req = ddr_cnt != 2'd0;
  assign o_line_err = line_err;
endmodule

// File: tb/tb_vpo_line_unpack.sv
// tb_vpo_line_unpack: randomized and directed stimulus checked every cycle against a queue-based line model.
module tb_vpo_line_unpack;
  logic clk = 1'b0;
  logic rst, soft_rst, syn_v, line_start, rd_en, pix_vld, pix_rdy, pix_last, ddr_req, line_err;
  logic [11:0] pix_num;
  logic [7:0] rd_addr;
  logic [127:0] rd_data;
  logic [15:0] pix_data;
  vpo_line_unpack dut (
    .i_sclk(clk), .i_rst(rst), .i_soft_rst(soft_rst), .i_syn_v(syn_v),
    .i_line_start(line_start), .i_pix_num(pix_num), .o_ram_rd_addr(rd_addr),
    .o_ram_rd_en(rd_en), .i_ram_rd_data(rd_data), .o_pix_vld(pix_vld),
    .i_pix_rdy(pix_rdy), .o_pix_data(pix_data), .o_pix_last(pix_last),
    .o_ddr_req(ddr_req), .o_line_err(line_err)
  );
  always #5 clk = ~clk;
  localparam int BIG = 1 << 30;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [127:0] ram [256];
  logic [15:0] expq [$];
  int trig [$];
  int exp_addr, exp_nword, nreads, started, npix_out, err_cnt;
  int busy_until = -10, err_due = -10, syn_det = -10, first_vld, last_hs, ddr_rise = -10;
  logic [15:0] last_val, first_val, pv_data;
  bit running = 0, seen = 0, rst_prev = 0, syn_last = 0, prev_ddr = 0, rdy_rand = 0;
  bit pv_vld = 0, pv_rdy = 0, pv_last = 0;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int n);
    nreads = 0;
    npix_out = 0;
    err_cnt = 0;
    pix_num = 12'(n);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while ((running || cyc <= busy_until) && k < budget) begin
      step();
      k++;
    end
    check(!(running || cyc <= busy_until), "line_timeout", k, budget);
    repeat (6) step();
  endtask

  task automatic fill_ramp();
    for (int w = 0; w < 256; w++)
      for (int j = 0; j < 8; j++) ram[w][j*16 +: 16] = 16'(w * 8 + j);
  endtask

  // line RAM with one-cycle read latency; garbage on idle cycles
  initial begin
    logic en;
    logic [7:0] a;
    rd_data = '0;
    forever begin
      @(negedge clk);
      en = rd_en;
      a = rd_addr;
      @(posedge clk);
      #1;
      rd_data = en ? ram[a] : {$urandom, $urandom, $urandom, $urandom};
    end
  end

  initial begin
    pix_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_rdy = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  always @(negedge clk) begin
    bit exp_ddr, abort_now;
    int n, j;
    logic [127:0] w;
    if (seen) begin
      if (rst_prev)
        check({pix_vld, pix_last, rd_en, ddr_req, line_err} == 5'd0 && pix_data == 16'd0 && rd_addr == 8'd0,
              "reset_outputs", {pix_vld, pix_last, rd_en, ddr_req, line_err, pix_data, rd_addr}, 0);
      exp_ddr = 0;
      foreach (trig[i]) if (cyc - trig[i] >= 1 && cyc - trig[i] <= 3) exp_ddr = 1;
      check(ddr_req === exp_ddr, "ddr_req", ddr_req, exp_ddr);
      if (ddr_req && !prev_ddr) ddr_rise = cyc;
      prev_ddr = ddr_req;
      check(line_err === (err_due == cyc), "line_err", line_err, err_due == cyc);
      if (line_err) err_cnt++;
      abort_now = running && syn_det == cyc;
      if (pv_vld && !pv_rdy)
        check(pix_vld === 1'b1 && pix_data === pv_data && pix_last === pv_last, "hold_stable",
              {pix_vld, pix_last, pix_data}, {1'b1, pv_last, pv_data});
      if (pix_vld === 1'b1) begin
        if (expq.size() == 0) check(0, "spurious_pixel", pix_data, 0);
        else begin
          if (first_vld < 0) first_vld = cyc;
          check(pix_data === expq[0], "pix_data", pix_data, expq[0]);
          check(pix_last === (expq.size() == 1), "pix_last", pix_last, expq.size() == 1);
          if (pix_rdy) begin
            if (npix_out % 8 == 0) started++;
            if (npix_out == 0) first_val = expq[0];
            last_val = expq[0];
            npix_out++;
            void'(expq.pop_front());
            if (expq.size() == 0) begin
              running = 0;
              last_hs = cyc;
              if (!abort_now) begin
                trig.push_back(cyc + 1);
                busy_until = cyc + 1;
              end
            end
          end
        end
      end
      if (rd_en === 1'b1) begin
        nreads++;
        check(rd_addr == 8'(exp_addr) && exp_addr < exp_nword, "rd_addr", rd_addr, exp_addr);
        check(nreads - started <= 2, "outstanding", nreads - started, 2);
        exp_addr++;
      end
      pv_vld = pix_vld;
      pv_rdy = pix_rdy;
      pv_last = pix_last;
      pv_data = pix_data;
      if (rst || soft_rst) begin
        expq.delete();
        trig.delete();
        running = 0;
        busy_until = -10;
        err_due = -10;
        syn_det = -10;
        syn_last = 0;
        exp_nword = 0;
        pv_vld = 0;
      end else begin
        if (abort_now) begin
          expq.delete();
          running = 0;
          busy_until = cyc;
          exp_nword = 0;
          pv_vld = 0;
        end
        if (syn_v && !syn_last) begin
          syn_det = cyc + 2;
          trig.push_back(cyc + 2);
        end
        syn_last = syn_v;
        if (line_start) begin
          if (cyc <= busy_until) err_due = cyc + 1;
          else if (pix_num != 0) begin
            n = (pix_num > 2048) ? 2048 : int'(pix_num);
            expq.delete();
            for (int k = 0; k < n; k++) begin
              w = ram[k / 8];
`ifdef VPO_PIX_MSB_FIRST_EN
              j = 7 - k % 8;
`else
              j = k % 8;
`endif
              expq.push_back(w[j*16 +: 16]);
            end
            running = 1;
            busy_until = BIG;
            exp_addr = 0;
            exp_nword = (n + 7) / 8;
            nreads = 0;
            started = 0;
            npix_out = 0;
            first_vld = -1;
          end
        end
      end
      rst_prev = rst || soft_rst;
    end
    if (rst) seen = 1;
  end

  initial begin
    int t0, s;
    rst = 1'b1; soft_rst = 1'b0; syn_v = 1'b0; line_start = 1'b0; pix_num = '0;
    fill_ramp();
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    // full line, no backpressure
    t0 = cyc;
    start_line(2048);
    wait_done(2100);
    check(first_vld - t0 == 3, "full_first_vld", first_vld - t0, 3);
    check(last_hs - t0 == 2050, "full_last_hs", last_hs - t0, 2050);
    check(nreads == 256, "full_nreads", nreads, 256);
    check(npix_out == 2048, "full_npix", npix_out, 2048);
    // partial last word
    t0 = cyc;
    start_line(13);
    wait_done(100);
    check(nreads == 2, "part_nreads", nreads, 2);
    check(npix_out == 13, "part_npix", npix_out, 13);
`ifdef VPO_PIX_MSB_FIRST_EN
    check(last_val == 16'd11, "part_last_val", last_val, 11);
`else
    check(last_val == 16'd12, "part_last_val", last_val, 12);
`endif
    check(last_hs - t0 == 15, "part_last_hs", last_hs - t0, 15);
    // pixel order within a word
    start_line(8);
    wait_done(50);
`ifdef VPO_PIX_MSB_FIRST_EN
    check(first_val == 16'd7, "first_val", first_val, 7);
`else
    check(first_val == 16'd0, "first_val", first_val, 0);
`endif
    check(last_val == 16'd7 - first_val, "last_val8", last_val, 16'd7 - first_val);
    // zero length is ignored
    start_line(0);
    repeat (8) step();
    check(nreads == 0 && npix_out == 0, "zero_len", {nreads, npix_out}, 0);
    // oversize is clamped
    start_line(3000);
    wait_done(2100);
    check(npix_out == 2048 && nreads == 256, "clamp", {npix_out, nreads}, {32'd2048, 32'd256});
    // overlapping line start
    start_line(64);
    repeat (10) step();
    pix_num = 12'd5;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    wait_done(200);
    check(npix_out == 64 && err_cnt == 1, "overlap", {npix_out, err_cnt}, {32'd64, 32'd1});
    // frame prefetch
    s = cyc;
    syn_v = 1'b1;
    repeat (8) step();
    check(ddr_rise - s == 3, "syn_prefetch", ddr_rise - s, 3);
    syn_v = 1'b0;
    repeat (4) step();
    // frame sync aborts a running line
    start_line(200);
    repeat (20) step();
    s = cyc;
    syn_v = 1'b1;
    wait_done(50);
    check(npix_out == 21, "abort_npix", npix_out, 21);
    check(ddr_rise - s == 3, "abort_prefetch", ddr_rise - s, 3);
    syn_v = 1'b0;
    repeat (4) step();
    // soft reset mid-line, then restart
    start_line(300);
    for (int k = 0; k < 200 && npix_out < 100; k++) step();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    repeat (3) step();
    start_line(16);
    wait_done(100);
    check(npix_out == 16 && nreads == 2, "after_soft_rst", {npix_out, nreads}, {32'd16, 32'd2});
    // randomized backpressure and contents
    for (int w = 0; w < 256; w++) ram[w] = {$urandom, $urandom, $urandom, $urandom};
    rdy_rand = 1;
    start_line(64);
    wait_done(400);
    check(npix_out == 64, "bp_npix", npix_out, 64);
    for (int i = 0; i < 25; i++) begin
      int n;
      n = $urandom_range(1, 300);
      start_line(n);
      if ($urandom_range(0, 3) == 0) begin
        repeat (5) step();
        pix_num = 12'd7;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
      end
      wait_done(n * 6 + 100);
      repeat ($urandom_range(0, 5)) step();
    end
    rdy_rand = 0;
    repeat (5) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vpo_line_unpack.md
# vpo_line_unpack

Downstream consumer of the one-line 256 x 128-bit read RAM that the DDR read controller fills. On each line start it reads the RAM's 128-bit words and unpacks each word into eight 16-bit pixels. It emits the pixels on a valid/ready stream to the video output stage. It also generates the 3-cycle `ddr_req` pulse that makes the DDR read controller prefetch the next line during blanking.

## Interface
- `PIX_W`, default 16, pixel width; fixed 128/`PIX_W` = 8 pixels per RAM word.
- `i_sclk`, input, 1: sole clock; the same clock as the DDR read controller.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_soft_rst`, input, 1: synchronous clear, same effect as `i_rst`.
- `i_syn_v`, input, 1: frame sync. Its rising edge starts a frame.
- `i_line_start`, input, 1: single-cycle pulse that starts readout of one line.
- `i_pix_num`, input, 12: pixels per line, 1..2048. Sampled at `i_line_start`.
- `o_ram_rd_addr`, output, 8: line RAM read address, equal to the word index.
- `o_ram_rd_en`, output, 1: RAM read strobe. Read latency is fixed at 1 cycle.
- `i_ram_rd_data`, input, 128: RAM read data, valid on the cycle after `o_ram_rd_en`.
- `o_pix_vld`, output, 1: pixel valid.
- `i_pix_rdy`, input, 1: downstream ready.
- `o_pix_data`, output, 16: pixel data.
- `o_pix_last`, output, 1: qualifies the last pixel of the line.
- `o_ddr_req`, output, 1: fetch request to the DDR read controller, held high for exactly 3 cycles.
- `o_line_err`, output, 1: 1-cycle pulse when `i_line_start` arrives while a line is still being read out.

## Operation
- Reset values: every output is 0. The FSM is in IDLE. All counters and flags are cleared.
- Line setup at `i_line_start`:
  - `npix` = min(`i_pix_num`, 2048) is latched.
  - `nword` = ceil(`npix`/8) is latched, range 1..256.
  - `i_pix_num` = 0 causes the pulse to be ignored.
- FSM states and transitions:
  - IDLE goes to RUN on a valid `i_line_start`.
  - RUN goes to DONE when the last pixel is accepted (`o_pix_vld & i_pix_rdy & o_pix_last`).
  - DONE goes to IDLE after one cycle. DONE loads the `o_ddr_req` pulse.
- Buffering in RUN:
  - Current-word register CUR holds the word being output and its pixel index `pidx`, 0..7.
  - Staging register NXT holds one word, with flag `nxt_vld`.
  - A RAM read is issued when all of the following hold: no read is in flight, `nxt_vld`=0, and fewer than `nword` reads have been issued.
  - Returned data goes into CUR if CUR is empty, otherwise into NXT.
- Pixel output:
  - `o_pix_data` = CUR[`pidx`*16 +: 16], so pixel 0 is bits [15:0].
  - `pidx` advances on each handshake.
  - After `pidx`=7, or after the last valid pixel of a partial last word, CUR reloads from NXT in the same cycle when `nxt_vld`=1.
- Pixel count:
  - A 12-bit pixel counter drives `o_pix_last` when it reaches `npix`-1.
  - Pixels beyond `npix` inside the last word are never presented.
- Backpressure:
  - While `i_pix_rdy`=0, `o_pix_vld`, `o_pix_data` and `o_pix_last` hold stable.
  - No read is issued while both CUR and NXT are full.
- Fetch requests (`o_ddr_req`):
  - A 3-cycle pulse is generated on entry to DONE.
  - A 3-cycle pulse is also generated 3 cycles after the `i_syn_v` rising edge, which prefetches line 0. The edge is detected on a 2-flop synchronised copy.
  - A new trigger that arrives while a pulse is in progress restarts the 3-cycle count.
- Overlapping line start:
  - `i_line_start` in RUN or DONE is ignored. The current line continues.
  - `o_line_err` pulses on the next cycle.
- `i_syn_v` rising edge during RUN aborts the line:
  - The FSM goes to IDLE.
  - CUR and NXT are invalidated. Any in-flight read is discarded.
  - The prefetch `o_ddr_req` is still issued.
- `i_rst` / `i_soft_rst` mid-line aborts immediately. All outputs are 0 on the next cycle.

## Timing
- `i_line_start` high at cycle 0:
  - Cycle 1: `o_ram_rd_en`=1 with `o_ram_rd_addr`=0.
  - Cycle 2: data captured into CUR.
  - Cycle 3: `o_pix_vld`=1 with pixel 0.
- With `i_pix_rdy` held at 1, pixels stream one per cycle with no bubbles. The word n+1 read is issued while word n is being output.
- The line occupies `npix`+2 cycles from `i_line_start` to the last handshake.
- `o_ddr_req` rises the cycle after DONE and stays high for exactly 3 cycles.
- `o_line_err` is asserted 1 cycle after the offending `i_line_start`.

## Configuration
- Macro `VPO_PIX_MSB_FIRST_EN`.
  - Defined: pixel 0 = bits [127:112], and `pidx` indexes from the top of the word.
  - Undefined (default): pixel 0 = bits [15:0].
  - Partial-word truncation, counts and timing are identical in both cases.

## Test plan
- Full line: `i_pix_num`=2048, ramp RAM, `i_pix_rdy`=1 → 256 reads at addresses 0..255. 2048 pixels stream contiguously from cycle 3. `o_pix_last` is asserted on pixel 2047. `o_ddr_req` is high for 3 cycles starting 1 cycle after DONE.
- Partial word: `i_pix_num`=13 → 2 reads. Exactly 13 pixels are output; the last is word1[79:64]. `o_pix_last` is asserted on the 13th pixel.
- Backpressure: `npix`=64, `i_pix_rdy` toggles 1-0-0-1 randomly → output holds stable while not ready. No pixel is lost or duplicated. Reads never exceed 2 outstanding words, counting NXT and in flight.
- Frame prefetch: `i_syn_v` rises → `o_ddr_req` is high for 3 cycles, starting 3 cycles after the edge. A `i_syn_v` edge during RUN aborts the line with `o_pix_vld`=0 next cycle.
- Errors: `i_line_start` during RUN → `o_line_err` is a 1-cycle pulse and the line completes normally. `i_pix_num`=0 → no reads and no pixels. `i_pix_num`=3000 → clamped to 2048.
- Reset mid-line: `i_soft_rst` at pixel 100 → all outputs are 0 next cycle. A following `i_line_start` restarts at address 0.
- Macro build: with `VPO_PIX_MSB_FIRST_EN` defined, `npix`=8 → pixels are output as bits [127:112] down to [15:0].
